// File: rtl/crc_pkg.sv
// crc_pkg: shared word/entry types and FSM state encodings for the crcgen feeder
package crc_pkg;
    typedef logic [15:0] crc_word_t;
    typedef struct packed {
        logic      last;
        crc_word_t w;
    } crc_fifo_entry_t;
    typedef enum logic {P_EMPTY, P_HI} pack_state_t;
    typedef enum logic {O_IDLE, O_GUARD} issue_state_t;
    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;
endpackage

// File: rtl/crc_word_fifo.sv
// crc_word_fifo: small word FIFO with sync clear; simultaneous push/pop legal when full
module crc_word_fifo
    import crc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  crc_fifo_entry_t wdata,
    output crc_fifo_entry_t rdata,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    crc_fifo_entry_t mem [DEPTH];
    assign rdata = mem[rptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/crc_byte_packer.sv
// crc_byte_packer: packs a byte stream MSB-first into 16-bit words and
// issues them to crcgen, at most one every two cycles and never while busy.
module crc_byte_packer
    import crc_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    input  logic        flush,
    input  logic        crc_busy,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        finish,
    output logic [15:0] words_out
);
    pack_state_t     p_state, p_next;
    issue_state_t    o_state, o_next;
    logic            alive, accept, push, pop, full, empty;
    logic [7:0]      hi;
    crc_fifo_entry_t wentry, rentry;
    assign pop      = o_state == O_IDLE && !empty && !crc_busy && !flush;
    assign in_ready = alive && !flush && (!full || pop);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (p_state == P_HI || in_last);
    assign wentry.last = p_state == P_HI ? in_last : 1'b1;
    assign wentry.w    = p_state == P_HI ? {hi, in_byte} : {in_byte, PAD_BYTE};
    crc_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (rentry),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        p_next = flush ? P_EMPTY : !accept ? p_state : (p_state == P_EMPTY && !in_last) ? P_HI : P_EMPTY;
        o_next = (!flush && pop) ? O_GUARD : O_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state <= P_EMPTY;
            o_state <= O_IDLE;
        end else begin
            p_state <= p_next;
            o_state <= o_next;
        end
    end
    // alive holds in_ready low until the first clock after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive      <= 1'b0;
            hi         <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            finish     <= 1'b0;
            words_out  <= '0;
        end else begin
            alive      <= 1'b1;
            data_valid <= pop;
            finish     <= pop && rentry.last;
            if (accept && p_state == P_EMPTY) hi <= in_byte;
            if (pop) data <= rentry.w;
            words_out <= flush ? '0 : (pop && words_out != 16'hFFFF) ? words_out + 16'd1 : words_out;
        end
    end
endmodule

// File: tb/tb_crc_byte_packer.sv
// tb_crc_byte_packer: directed vectors with hand-computed words for the crcgen feeder
module tb_crc_byte_packer;
    logic        clk = 0, rst = 0, in_valid = 0, in_last = 0, flush = 0, crc_busy = 0;
    logic [7:0]  in_byte = '0;
    logic        in_ready, data_valid, finish, in_ready_f, data_valid_f, finish_f;
    logic [15:0] data, words_out, data_f, words_out_f;
    int          checks = 0, errors = 0, cyc = 0;
    logic [16:0] q[$];
    int          qc[$];
    logic [15:0] qf[$];

    crc_byte_packer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .in_last(in_last), .flush(flush), .crc_busy(crc_busy), .data(data),
        .data_valid(data_valid), .finish(finish), .words_out(words_out)
    );
    crc_byte_packer #(.DEPTH(4), .PAD_BYTE(8'hFF)) dut_ff (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f), .in_byte(in_byte),
        .in_last(in_last), .flush(flush), .crc_busy(crc_busy), .data(data_f),
        .data_valid(data_valid_f), .finish(finish_f), .words_out(words_out_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (data_valid) begin
            q.push_back({finish, data});
            qc.push_back(cyc);
        end
        if (data_valid_f) qf.push_back(data_f);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %0s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        in_valid = 1;
        in_byte  = b;
        in_last  = l;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (in_ready) break;
            @(negedge clk);
        end
        if (!in_ready) check("send_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
        in_last = 0;
        @(negedge clk);
    endtask

    task automatic expect_word(input string tag, input logic [15:0] w, input logic f, output int c);
        logic [16:0] e;
        c = 0;
        check({tag, "_avail"}, q.size() != 0, 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            c = qc.pop_front();
            check(tag, e[15:0], w);
            check({tag, "_fin"}, e[16], f);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] harsha [6];
        int c1, c2, c3;
        harsha = '{8'h48, 8'h41, 8'h52, 8'h53, 8'h48, 8'h41};
        #1 rst = 1;
        #3;
        check("rst_ready", in_ready, 0);
        check("rst_data", data, 0);
        check("rst_dv", data_valid, 0);
        check("rst_finish", finish, 0);
        check("rst_words", words_out, 0);
        idle(2);
        rst = 0;
        @(posedge clk);
        #1 check("ready_after_rst", in_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) send(harsha[i], i == 5);
        idle(8);
        expect_word("h_w0", 16'h4841, 0, c1);
        expect_word("h_w1", 16'h5253, 0, c2);
        expect_word("h_w2", 16'h4841, 1, c3);
        check("h_gap1", c2 - c1, 2);
        check("h_gap2", c3 - c2, 2);
        check("h_words", words_out, 3);

        qf.delete();
        send(8'h41, 0);
        send(8'h42, 0);
        send(8'h43, 1);
        idle(8);
        expect_word("abc_w0", 16'h4142, 0, c1);
        expect_word("abc_w1", 16'h4300, 1, c1);
        check("abc_ff_cnt", qf.size(), 2);
        if (qf.size() == 2) check("abc_ff_pad", qf[1], 16'h43FF);
        check("abc_words", words_out, 5);

        q.delete(); qc.delete();
        crc_busy = 1;
        for (int i = 1; i <= 8; i++) send(8'(i), 0);
        idle(4);
        #1 check("full_ready", in_ready, 0);
        check("busy_no_dv", q.size(), 0);
        check("busy_words", words_out, 5);
        in_valid = 1; in_byte = 8'h09; in_last = 1;
        idle(3);
        #1 check("full_block", in_ready, 0);
        @(negedge clk);
        crc_busy = 0;
        #1 check("pop_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0; in_last = 0;
        @(negedge clk);
        #1 check("still_full", in_ready, 0);
        idle(16);
        expect_word("f_w0", 16'h0102, 0, c1);
        expect_word("f_w1", 16'h0304, 0, c1);
        expect_word("f_w2", 16'h0506, 0, c1);
        expect_word("f_w3", 16'h0708, 0, c1);
        expect_word("f_w4", 16'h0900, 1, c1);
        check("f_extra", q.size(), 0);
        check("f_ready_back", in_ready, 1);
        check("f_words", words_out, 10);

        send(8'h48, 0);
        send(8'h41, 0);
        send(8'h52, 0);
        #2 rst = 1;
        #1 check("mid_rst_data", data, 0);
        check("mid_rst_dv", data_valid, 0);
        check("mid_rst_finish", finish, 0);
        check("mid_rst_words", words_out, 0);
        check("mid_rst_ready", in_ready, 0);
        @(negedge clk);
        rst = 0;
        q.delete(); qc.delete();
        idle(1);
        send(8'h41, 0);
        send(8'h42, 1);
        idle(6);
        expect_word("r_w0", 16'h4142, 1, c1);
        check("r_words", words_out, 1);

        q.delete(); qc.delete();
        crc_busy = 1;
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        send(8'h44, 0);
        send(8'h55, 0);
        check("pre_flush_words", words_out, 1);
        flush = 1; in_valid = 1; in_byte = 8'h77; in_last = 0;
        #1 check("flush_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 0; in_valid = 0; crc_busy = 0;
        check("flush_words", words_out, 0);
        check("flush_dv", data_valid, 0);
        idle(8);
        check("flush_no_dv", q.size(), 0);
        send(8'h88, 0);
        send(8'h99, 1);
        idle(6);
        expect_word("fl_w0", 16'h8899, 1, c1);
        check("fl_words", words_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
